// File: rtl/fir_capture_buffer_pkg.sv
// Shared types and default widths for the FIR capture buffer.
// The default sample width matches the lagrange_fir output width.
package fir_capture_pkg;

    localparam int CAP_DATA_W = 16;
    localparam int CAP_ADDR_W = 8;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_READOUT = 2'd3
    } cap_state_t;

endpackage

// File: rtl/fir_capture_buffer_if.sv
// Readout stream of the capture buffer: valid/ready with a last-beat marker.
// The buffer drives the master side; the consumer holds the slave side.
interface fir_capture_buffer_if
    import fir_capture_pkg::*;
#(
    parameter int DATA_W = CAP_DATA_W
);

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/fir_capture_buffer_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The read register only loads on re, so it holds the last beat during a stall.
module capture_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Synchronous read register; cleared by reset so the readout bus idles at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/fir_capture_buffer.sv
// Pre/post-trigger capture buffer: keeps a circular sample history, freezes one
// DEPTH-sample window around a rising threshold crossing and streams it out oldest first.
module fir_capture_buffer
    import fir_capture_pkg::*;
#(
    parameter int DATA_W   = CAP_DATA_W,
    parameter int ADDR_W   = CAP_ADDR_W,
    parameter int POST_LEN = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic                     arm,
    input  logic signed [DATA_W-1:0] threshold,
    fir_capture_buffer_if.master     rd,
    output logic                     busy,
    output logic                     done
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int PRE_LEN = DEPTH - POST_LEN;
    localparam int CNT_W   = ADDR_W + 1;

    localparam logic [ADDR_W-1:0]        PRE_LEN_C   = ADDR_W'(PRE_LEN);
    localparam logic [ADDR_W-1:0]        POST_LAST_C = ADDR_W'(POST_LEN - 1);
    localparam logic [CNT_W-1:0]         DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]         BEAT_LAST_C = CNT_W'(DEPTH - 1);
    localparam logic signed [DATA_W-1:0] MOST_NEG_C  = {1'b1, {(DATA_W-1){1'b0}}};
    // A one-sample post window has nothing left to capture after the trigger.
    localparam cap_state_t TRIG_NEXT_C = (POST_LEN == 1) ? CAP_READOUT : CAP_CAPTURE;

    cap_state_t state_r;
    cap_state_t state_nx_s;

    logic signed [DATA_W-1:0] thr_r;
    logic signed [DATA_W-1:0] prev_r;
    logic [ADDR_W-1:0]        wptr_r;
    logic [ADDR_W-1:0]        fill_r;
    logic [ADDR_W-1:0]        post_r;
    logic [ADDR_W-1:0]        start_r;
    logic [ADDR_W-1:0]        rptr_r;
    logic [CNT_W-1:0]         issued_r;
    logic                     out_valid_r;
    logic                     out_last_r;
    logic                     busy_r;
    logic                     done_r;

    logic                     we_s;
    logic                     cross_s;
    logic                     trig_s;
    logic                     issue_s;
    logic                     xfer_s;
    logic                     last_xfer_s;
    logic                     enter_rd_s;
    logic [ADDR_W-1:0]        start_s;
    logic [DATA_W-1:0]        rdata_s;

    assign we_s        = sample_valid && ((state_r == CAP_ARMED) || (state_r == CAP_CAPTURE));
    assign cross_s     = (prev_r < thr_r) && (sample_in >= thr_r);
    assign trig_s      = (state_r == CAP_ARMED) && sample_valid && cross_s && (fill_r >= PRE_LEN_C);
    assign start_s     = wptr_r - PRE_LEN_C;
    assign issue_s     = (state_r == CAP_READOUT) && (issued_r != DEPTH_C)
                         && (!out_valid_r || rd.out_ready);
    assign xfer_s      = out_valid_r && rd.out_ready;
    assign last_xfer_s = xfer_s && out_last_r;
    assign enter_rd_s  = (state_nx_s == CAP_READOUT) && (state_r != CAP_READOUT);

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we_s),
        .waddr (wptr_r),
        .wdata (sample_in),
        .re    (issue_s),
        .raddr (rptr_r),
        .rdata (rdata_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= CAP_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            CAP_IDLE: begin
                if (arm) begin
                    state_nx_s = CAP_ARMED;
                end else begin
                    state_nx_s = CAP_IDLE;
                end
            end
            CAP_ARMED: begin
                if (trig_s) begin
                    state_nx_s = TRIG_NEXT_C;
                end else begin
                    state_nx_s = CAP_ARMED;
                end
            end
            CAP_CAPTURE: begin
                if (sample_valid && (post_r == POST_LAST_C)) begin
                    state_nx_s = CAP_READOUT;
                end else begin
                    state_nx_s = CAP_CAPTURE;
                end
            end
            CAP_READOUT: begin
                if (last_xfer_s) begin
                    state_nx_s = CAP_IDLE;
                end else begin
                    state_nx_s = CAP_READOUT;
                end
            end
            default: begin
                state_nx_s = CAP_IDLE;
            end
        endcase
    end

    // Capture side: threshold latch, write pointer, prefill and post counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            thr_r   <= '0;
            prev_r  <= '0;
            wptr_r  <= '0;
            fill_r  <= '0;
            post_r  <= '0;
            start_r <= '0;
        end else begin
            case (state_r)
                CAP_IDLE: begin
                    if (arm) begin
                        thr_r  <= threshold;
                        prev_r <= MOST_NEG_C;
                        wptr_r <= '0;
                        fill_r <= '0;
                    end
                end
                CAP_ARMED: begin
                    if (sample_valid) begin
                        wptr_r <= wptr_r + ADDR_W'(1);
                        prev_r <= sample_in;
                        if (fill_r != PRE_LEN_C) begin
                            fill_r <= fill_r + ADDR_W'(1);
                        end
                        if (trig_s) begin
                            post_r  <= ADDR_W'(1);
                            start_r <= start_s;
                        end
                    end
                end
                CAP_CAPTURE: begin
                    if (sample_valid) begin
                        wptr_r <= wptr_r + ADDR_W'(1);
                        post_r <= post_r + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Readout side: read pointer, beat counter and the registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_r      <= '0;
            issued_r    <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != CAP_IDLE);
            done_r <= last_xfer_s;
            if (enter_rd_s) begin
                // On a direct ARMED->READOUT hop start_r is not yet loaded.
                rptr_r   <= (state_r == CAP_ARMED) ? start_s : start_r;
                issued_r <= '0;
            end else if (issue_s) begin
                rptr_r   <= rptr_r + ADDR_W'(1);
                issued_r <= issued_r + CNT_W'(1);
            end
            if (issue_s) begin
                out_valid_r <= 1'b1;
                out_last_r  <= (issued_r == BEAT_LAST_C);
            end else if (xfer_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
        end
    end

    assign rd.out_data  = rdata_s;
    assign rd.out_valid = out_valid_r;
    assign rd.out_last  = out_last_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_fir_capture_buffer.sv
// Directed bench for fir_capture_buffer with DEPTH = 16, POST_LEN = 8 (PRE_LEN = 8).
// Scenario table drives capture/readout runs; reset-abort runs are hand-written.
module tb_fir_capture_buffer;
    import fir_capture_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               arm;
    logic signed [15:0] threshold;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    fir_capture_buffer_if #(.DATA_W(16)) rd_if ();

    fir_capture_buffer #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .POST_LEN (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .arm          (arm),
        .threshold    (threshold),
        .rd           (rd_if.master),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                thr;
        int                kind;       // 0: ramp 0,1,2..  1: 0,5,0,5..
        int                vper;       // sample_valid every vper cycles
        bit                ready_alt;  // out_ready 1,0,1,0..
        bit                disturb;    // arm + threshold -100 in CAPTURE and READOUT
        int                last_post;  // pattern index of the last post-trigger sample
        logic [15:0][15:0] exp;
    } case_t;

    case_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int kind, input int i);
        if (kind == 0) return 16'(i);
        return (i % 2 == 1) ? 16'd5 : 16'd0;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(rd_if.out_valid), 32'd0);
        chk({tag, "_last"},  32'(rd_if.out_last),  32'd0);
        chk({tag, "_data"},  32'(rd_if.out_data),  32'd0);
        chk({tag, "_busy"},  32'(busy),            32'd0);
        chk({tag, "_done"},  32'(done),            32'd0);
        chk({tag, "_state"}, 32'(dut.state_r),     32'(CAP_IDLE));
    endtask

    task automatic run_case(input int c, input int rst_idx, input int rst_beat);
        int   idx, beats, lp_it, fv_cyc;
        bit   seen_v, stall, fin;
        logic [15:0] held_d;
        logic held_l;
        idx = 0; beats = 0; lp_it = -100; fv_cyc = -1;
        seen_v = 1'b0; stall = 1'b0; fin = 1'b0; held_d = 16'd0; held_l = 1'b0;
        threshold = 16'(tbl[c].thr);
        sample_valid = 1'b0;
        rd_if.out_ready = 1'b1;
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        chk("busy_after_arm", 32'(busy), 32'd1);
        for (int it = 0; it < 600 && !fin; it++) begin
            arm = 1'b0;
            if (rst_beat > 0 && beats == rst_beat) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                check_idle("rst_readout");
                return;
            end
            if (it % tbl[c].vper == 0) begin
                sample_valid = 1'b1;
                sample_in = pat(tbl[c].kind, idx);
                if (idx == tbl[c].last_post) lp_it = it;
                if (idx == rst_idx) reset = 1'b1;
                if (tbl[c].disturb && idx == 23) begin
                    arm = 1'b1;
                    threshold = -16'sd100;
                end
                idx++;
            end else begin
                sample_valid = 1'b0;
            end
            rd_if.out_ready = tbl[c].ready_alt ? (it % 2 == 0) : 1'b1;
            if (tbl[c].disturb && beats == 3 && rd_if.out_valid) arm = 1'b1;
            if (rd_if.out_valid && rd_if.out_ready) begin
                if (beats < 16) begin
                    chk("beat_data", 32'(rd_if.out_data), 32'(tbl[c].exp[beats]));
                    chk("beat_last", 32'(rd_if.out_last), 32'(beats == 15));
                end
                beats++;
            end
            stall  = rd_if.out_valid && !rd_if.out_ready;
            held_d = rd_if.out_data;
            held_l = rd_if.out_last;
            @(posedge clk); #1;
            if (reset) begin
                reset = 1'b0;
                check_idle("rst_capture");
                return;
            end
            if (stall) begin
                chk("stall_valid", 32'(rd_if.out_valid), 32'd1);
                chk("stall_data",  32'(rd_if.out_data),  32'(held_d));
                chk("stall_last",  32'(rd_if.out_last),  32'(held_l));
            end
            // Observation after the edge ending cycle it belongs to cycle it+1.
            if (rd_if.out_valid && !seen_v) begin
                seen_v = 1'b1;
                fv_cyc = it + 1;
            end
            if (done) begin
                fin = 1'b1;
                chk("done_busy",  32'(busy),            32'd0);
                chk("done_valid", 32'(rd_if.out_valid), 32'd0);
            end
        end
        arm = 1'b0;
        sample_valid = 1'b0;
        if (!fin) begin
            chk("timeout_no_done", 32'd0, 32'd1);
        end else begin
            chk("beat_count", 32'(beats), 32'd16);
            chk("first_valid_latency", 32'(fv_cyc - lp_it), 32'd2);
            for (int k = 0; k < (tbl[c].disturb ? 30 : 3); k++) begin
                @(posedge clk); #1;
                chk("done_single_pulse", 32'(done), 32'd0);
                chk("idle_after_done",   32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        // Basic ramp: trigger on 20, window holds samples 12..27.
        tbl[0].thr = 20; tbl[0].kind = 0; tbl[0].vper = 1; tbl[0].ready_alt = 1'b0;
        tbl[0].disturb = 1'b0; tbl[0].last_post = 27;
        // Alternating 0/5: trigger at index 9, window holds indices 1..16.
        tbl[1].thr = 3; tbl[1].kind = 1; tbl[1].vper = 1; tbl[1].ready_alt = 1'b0;
        tbl[1].disturb = 1'b0; tbl[1].last_post = 16;
        for (int k = 0; k < 16; k++) begin
            tbl[0].exp[k] = 16'(12 + k);
            tbl[1].exp[k] = (k % 2 == 0) ? 16'd5 : 16'd0;
        end
        tbl[2] = tbl[0]; tbl[2].ready_alt = 1'b1;
        tbl[3] = tbl[0]; tbl[3].vper = 3;
        tbl[4] = tbl[0]; tbl[4].disturb = 1'b1;

        reset = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample_in = 16'sd0;
        threshold = 16'sd0; rd_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int c = 0; c < 5; c++) begin
            run_case(c, -1, 0);
        end

        run_case(0, 23, 0);
        run_case(0, -1, 0);
        run_case(0, -1, 5);
        run_case(0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_capture_buffer.md
# fir_capture_buffer

Pre/post-trigger capture buffer on the output side of `lagrange_fir`. It takes the filtered sample stream (`delay_signal`) and holds a circular history of samples. On a rising threshold crossing it freezes one window of `DEPTH` samples around the trigger, then reads the window out, oldest first, over a valid/ready stream. It is the read-back counterpart of the ROM-driven stimulus path, so hardware and benches can compare delayed output against source without file dumps.

## Interface
- `DATA_W`, 16: sample width, two's complement.
- `ADDR_W`, 8: buffer address width; `DEPTH` = 2^ADDR_W.
- `POST_LEN`, 128: samples stored from the trigger sample onward, trigger sample included. Range 1..DEPTH-1.
- `PRE_LEN` is derived: PRE_LEN = DEPTH − POST_LEN.

Ports:
- `clk`  in  1  single clock domain.
- `reset`  in  1  synchronous, active-high.
- `sample_in`  in  DATA_W  signed filter output.
- `sample_valid`  in  1  `sample_in` is a new sample this cycle.
- `arm`  in  1  one-cycle pulse that starts a capture.
- `threshold`  in  DATA_W  signed trigger level. Sampled on the `arm` cycle.
- `out_data`  out  DATA_W  readout sample.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_last`  out  1  marks the final beat of the window (beat DEPTH).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States: IDLE, ARMED, CAPTURE, READOUT.
- **IDLE**
  - `arm` = 1: latch `threshold`, clear write pointer and fill count, go to ARMED.
  - Samples are ignored in IDLE.
- **ARMED**
  - Each valid sample is written at `wptr`; `wptr` increments mod DEPTH.
  - Fill count saturates at PRE_LEN.
  - The previous valid sample is registered. `prev` resets to the most negative value on arm.
  - Trigger condition: `prev` < thr and `sample_in` ≥ thr, signed compare, **and** fill count (before this write) ≥ PRE_LEN.
  - Crossings that fail the fill test are ignored.
  - On trigger: write the trigger sample, set post count = 1, record start = (trigger address − PRE_LEN) mod DEPTH, go to CAPTURE.
  - If POST_LEN = 1, go straight to READOUT.
- **CAPTURE**
  - Each valid sample is written and increments post count.
  - When post count reaches POST_LEN, go to READOUT.
  - Thresholds are not evaluated in this state.
- **READOUT**
  - Input samples are ignored.
  - DEPTH beats are read starting at start address, with wrap-around.
  - After the beat with `out_last` is accepted, pulse `done` and go to IDLE.
- `arm` outside IDLE is ignored.
- `threshold` changes after the `arm` cycle have no effect on the current capture.

## Timing
- Reset values: `out_data` 0, `out_valid` 0, `out_last` 0, `busy` 0, `done` 0, state IDLE, all pointers and counts 0.
- `reset` has priority over every other input, in any state including mid-CAPTURE and mid-READOUT. The partial window is discarded.
- Buffer RAM: synchronous read, 1-cycle latency, write-first not required (no read/write overlap by construction).
- Write occurs in the same cycle as the `sample_valid` that carries the sample.
- Trigger decision uses that cycle's sample. The state changes on the next edge.
- Readout issue rule:
  - Issue a read when state = READOUT, beats remain, and (`out_valid` = 0 or `out_ready` = 1).
  - `out_valid` and `out_data` update on the following edge.
  - Sustained `out_ready` = 1 gives one beat per cycle after a 1-cycle start latency.
- Stall: `out_valid` = 1 and `out_ready` = 0 holds `out_data`, `out_valid` and `out_last` stable.
- Transfer occurs when `out_valid` and `out_ready` are both high.
- After the last transfer, `out_valid` drops on the next edge, the same edge where `done` = 1 and `busy` = 0.
- Capture latency: the last post sample is written in cycle N; READOUT is entered at N+1; the first `out_valid` appears at N+2.

## Structure
- Package `fir_capture_pkg` contains:
  - the state enum (`CAP_IDLE`, `CAP_ARMED`, `CAP_CAPTURE`, `CAP_READOUT`);
  - default `DATA_W` (16) and `ADDR_W` (8), shared with the `lagrange_fir` sample width.
- Sub-module `capture_ram`: simple dual-port RAM, one write port and one synchronous read port, parameterised by DATA_W and ADDR_W.
- All control logic lives in the top level.

## Test plan
All scenarios use ADDR_W = 4 (DEPTH = 16) and POST_LEN = 8, so PRE_LEN = 8.
- **Basic capture:** arm with threshold 20, then ramp 0,1,2… with valid every cycle.
  - Trigger on sample 20.
  - Readout is 12..27 in order; `out_last` is set on 27; `done` pulses once; `busy` then falls.
- **Prefill gating:** arm with threshold 3, input alternating 0,5,0,5… (index 0 = 0).
  - Crossings at indices 1, 3, 5 and 7 are ignored; trigger at index 9.
  - Readout is indices 1..16: 5,0,5,…,0.
- **Backpressure:** repeat the basic-capture case with `out_ready` = 1,0,1,0…
  - Exactly 16 beats, 12..27, no duplicates or drops.
  - `out_data` is stable during every stall cycle.
- **Sparse input:** repeat the basic-capture case with `sample_valid` high every 3rd cycle.
  - Same readout 12..27; invalid cycles neither write nor trigger.
- **Reset mid-operation:** assert `reset` for 1 cycle during CAPTURE, and again on a separate run after 5 readout beats.
  - Next cycle: all outputs 0 and state IDLE.
  - A fresh arm then reproduces the basic-capture result.
- **Ignored arm and threshold change:** pulse `arm` and change `threshold` to −100 during CAPTURE and during READOUT.
  - Window contents are unchanged.
  - No second capture starts.
